// File: rtl/gy_block_window1.sv
// Sobel vertical-gradient (Gy) magnitude for the left 3x3 window (columns 0..2)
// of a 3x4 pixel buffer, registered on enable_calc.
module gy_block_window1 (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [11:0][7:0] data_buffer,
  input  logic             enable_calc,
  output logic [10:0]      gy_out_1
);

  logic [9:0]  top_sum;
  logic [9:0]  bot_sum;
  logic [10:0] gy_diff;
  logic [10:0] gy_abs;

  // Row 1 has zero weight and column 3 belongs only to the sibling window.
  always_comb begin
    top_sum = {2'b00, data_buffer[0]} + {1'b0, data_buffer[1], 1'b0} + {2'b00, data_buffer[2]};
    bot_sum = {2'b00, data_buffer[8]} + {1'b0, data_buffer[9], 1'b0} + {2'b00, data_buffer[10]};
    gy_diff = {1'b0, bot_sum} - {1'b0, top_sum};
    gy_abs  = gy_diff[10] ? (11'd0 - gy_diff) : gy_diff;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gy_out_1 <= 11'd0;
    end else if (enable_calc) begin
      gy_out_1 <= gy_abs;
    end
  end

endmodule

// File: tb/tb_gy_block_window1.sv
// Directed self-checking bench for gy_block_window1 with hand-computed Gy magnitudes.
module tb_gy_block_window1;

  logic             tb_clk;
  logic             n_rst;
  logic [11:0][7:0] data_buffer;
  logic             enable_calc;
  logic [10:0]      gy_out_1;

  int checks;
  int failures;

  gy_block_window1 dut (
    .clk         (tb_clk),
    .n_rst       (n_rst),
    .data_buffer (data_buffer),
    .enable_calc (enable_calc),
    .gy_out_1    (gy_out_1)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [10:0] expected);
    checks++;
    assert (gy_out_1 === expected)
      $display("check %s: gy_out_1=%0d expected=%0d", tag, gy_out_1, expected);
    else begin
      failures++;
      $error("FAIL %s: gy_out_1=%0d expected=%0d", tag, gy_out_1, expected);
    end
  endtask

  // Top row and bottom row of window 1; every other index gets 'other'.
  task automatic set_rows(input logic [7:0] t0, t1, t2, b0, b1, b2, other);
    for (int i = 0; i < 12; i++) data_buffer[i] = other;
    data_buffer[0] = t0;  data_buffer[1] = t1;  data_buffer[2]  = t2;
    data_buffer[8] = b0;  data_buffer[9] = b1;  data_buffer[10] = b2;
  endtask

  task automatic set_split(input logic [7:0] lo, input logic [7:0] hi);
    for (int i = 0; i < 12; i++) data_buffer[i] = (i < 6) ? lo : hi;
  endtask

  // Present inputs at the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic en);
    @(negedge tb_clk);
    enable_calc = en;
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    n_rst       = 1'b1;
    enable_calc = 1'b0;
    set_split(8'd100, 8'd200);

    // Asynchronous reset before any clock edge.
    #2 n_rst = 1'b0;
    #1 check("reset_async", 11'd0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("reset_hold_disabled", 11'd0);
    end

    // Horizontal edge: top 400, bottom 800.
    set_split(8'd100, 8'd200);
    step(1'b1);
    check("horizontal_edge", 11'd400);

    // Extremes: top 0, bottom 255 -> 1020.
    set_rows(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0);
    step(1'b1);
    check("max_extreme", 11'd1020);

    // Flat field.
    for (int i = 0; i < 12; i++) data_buffer[i] = 8'd77;
    step(1'b1);
    check("flat_77", 11'd0);

    // Negative gradient: absolute value.
    set_split(8'd200, 8'd100);
    step(1'b1);
    check("negative_gradient", 11'd400);

    // Weighting: top 10+40+30=80, bottom 1+4+3=8 -> 72.
    set_rows(8'd10, 8'd20, 8'd30, 8'd1, 8'd2, 8'd3, 8'd0);
    step(1'b1);
    check("weights_neg", 11'd72);

    // Centre weight: top 510, bottom 255 -> 255.
    set_rows(8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0);
    step(1'b1);
    check("centre_weight", 11'd255);

    // Right column only: top 0, bottom 255 with middle row large -> 255.
    set_rows(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd250);
    step(1'b1);
    check("row1_ignored", 11'd255);

    // Hold: capture 400, then drop enable and clear buffer.
    set_split(8'd100, 8'd200);
    step(1'b1);
    check("capture_400", 11'd400);
    for (int i = 0; i < 12; i++) data_buffer[i] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      check("hold_disabled", 11'd400);
    end

    // Ignored column 3: changing indices 3, 7, 11 with enable high.
    set_split(8'd100, 8'd200);
    step(1'b1);
    check("recapture_400", 11'd400);
    data_buffer[3]  = 8'd255;
    data_buffer[7]  = 8'd0;
    data_buffer[11] = 8'd17;
    step(1'b1);
    check("col3_ignored", 11'd400);

    // Reset mid-stream with enable still high, pulsed between edges.
    @(negedge tb_clk);
    #1 n_rst = 1'b0;
    #1 check("reset_midstream", 11'd0);
    #1 n_rst = 1'b1;
    #1 check("reset_released", 11'd0);
    @(posedge tb_clk);
    #1 check("after_reset_enabled", 11'd400);
    enable_calc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gy_block_window1.md
Name: gy_block_window1

Overview:
- Computes the Sobel vertical-gradient (Gy) magnitude for the first (left) 3x3 window of a 3-row x 4-column pixel buffer in the edge-detection datapath.
- Sits after the pixel line buffer.
- Runs in parallel with the Gx block and with the sibling Gy block for window 2 (columns 1..3).
- Feeds the magnitude/threshold stage with a registered 11-bit result.

Parameters:
- None. Pixel width is fixed at 8 bits; buffer is fixed at 12 pixels; output is fixed at 11 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- data_buffer  input  12x8 (packed [11:0][7:0])  unsigned pixels, row-major, 3 rows x 4 columns; element index = row*4 + col.
- enable_calc  input  1  when high at a rising clk edge, a new result is captured.
- gy_out_1  output  11  registered absolute Gy of window 1, unsigned.

Behaviour:
- Window 1 covers rows 0..2, columns 0..2. With P(r,c) = data_buffer[r*4+c]:
  - Top row: T0 = [0], T1 = [1], T2 = [2].
  - Bottom row: B0 = [8], B1 = [9], B2 = [10].
  - Indices 3, 7 and 11 are ignored. Row 1 (indices 4..6) has zero weight.
- Kernel: [-1 -2 -1; 0 0 0; +1 +2 +1].
- Raw value: Gy = (B0 + 2*B1 + B2) - (T0 + 2*T1 + T2).
  - Compute each weighted sum as an unsigned 10-bit value (max 1020).
  - Compute the difference in 11-bit two's complement, range -1020..+1020.
- Output is |Gy|, 0..1020, zero-extended into 11 bits. Bit 10 is always 0. No saturation is needed and no overflow is possible.
- Combinational path: data_buffer -> sums -> difference -> absolute value.
- Register: gy_out_1 is a flip-flop.
  - If enable_calc = 1 at a rising clk edge, gy_out_1 <= |Gy| computed from the data_buffer present at that edge.
  - If enable_calc = 0, gy_out_1 holds its previous value.
- Latency: 1 clock. The result is visible after the first rising edge at which enable_calc is sampled high.
- Throughput: one result per cycle while enable_calc stays high. Each edge captures the current buffer contents.
- Reset: n_rst = 0 clears gy_out_1 to 0 immediately, with no clock required.
  - Reset asserted mid-operation discards the held result.
  - After n_rst deasserts, the output stays 0 until the next enabled edge.
- Changes on data_buffer while enable_calc = 0 have no effect on the output.
- No handshake and no done flag. The upstream controller owns enable_calc timing.

Test Plan:
- Reset: assert n_rst = 0 with enable_calc = 0 -> gy_out_1 = 0 asynchronously; it stays 0 after release until enable_calc goes high.
- Horizontal edge: indices 0..5 = 100, indices 6..11 = 200; after reset, set enable_calc = 1 for one edge -> gy_out_1 = 400 (bottom sum 800 minus top sum 400).
- Negative gradient: indices 0..5 = 200, indices 6..11 = 100 -> gy_out_1 = 400 (absolute value).
- Extremes and flat input:
  - Top row = 0, bottom row = 255 -> gy_out_1 = 1020.
  - All pixels = 77 -> gy_out_1 = 0.
- Hold and ignored pixels:
  - Capture 400, drop enable_calc, change the buffer to all 0 -> gy_out_1 stays 400 for several cycles.
  - Change only indices 3, 7 and 11 with enable_calc high -> result unchanged.
- Reset mid-stream: with enable_calc high and gy_out_1 = 400, pulse n_rst low between clock edges -> gy_out_1 = 0 at once, then 400 again on the first enabled edge after release.
